// File: rtl/frame_payload_checker_if.sv
// frame_payload_checker_if
// Bundles the serial payload stream from the frame synchroniser with the
// checker's status outputs.
//   DataOut / DataOutEn   : serial payload bit and its qualifier (master -> slave)
//   DataWrong / LenErr    : one-cycle error pulses                (slave -> master)
//   ErrCount [ERR_W]      : saturating error count                (slave -> master)
//   FrameCount [FCNT_W]   : completed frame count, wraps          (slave -> master)
//   Locked / Hunt         : link status flags                     (slave -> master)
// ERR_W / FCNT_W must match the parameters of the attached checker.
interface frame_payload_checker_if #(
    parameter int ERR_W  = 16,
    parameter int FCNT_W = 16
);
    logic              DataOut;
    logic              DataOutEn;
    logic              DataWrong;
    logic              LenErr;
    logic [ERR_W-1:0]  ErrCount;
    logic [FCNT_W-1:0] FrameCount;
    logic              Locked;
    logic              Hunt;

    modport master (
        output DataOut, DataOutEn,
        input  DataWrong, LenErr, ErrCount, FrameCount, Locked, Hunt
    );

    modport slave (
        input  DataOut, DataOutEn,
        output DataWrong, LenErr, ErrCount, FrameCount, Locked, Hunt
    );
endinterface

// File: rtl/frame_payload_checker.sv
// frame_payload_checker
// Deserialises the synchroniser's payload stream MSB-first into bytes,
// checks them against a self-seeding incrementing (mod-256) reference,
// checks each frame's length and keeps error/frame counters and a lock flag.
// Ports:
//   Clock : system clock, all state on rising edge
//   Reset : asynchronous active-high reset
//   bus   : frame_payload_checker_if.slave
//           in : DataOut, DataOutEn
//           out: DataWrong, LenErr, ErrCount, FrameCount, Locked, Hunt
// All outputs are registered; error pulses appear one cycle after the
// edge that completed the offending byte or ended the frame.
module frame_payload_checker #(
    parameter int PAYLOAD_BYTES = 31,
    parameter int LOCK_FRAMES   = 4,
    parameter int ERR_W         = 16,
    parameter int FCNT_W        = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    frame_payload_checker_if.slave  bus
);

    localparam logic [7:0] LP_PAYLOAD = 8'(PAYLOAD_BYTES);
    localparam logic [3:0] LP_LOCK    = 4'(LOCK_FRAMES);

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    state_t            r_state;
    logic [6:0]        r_sreg;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_byte_cnt;
    logic [7:0]        r_expected;
    logic [3:0]        r_good_run;
    logic              r_frame_bad;
    logic              r_en_d;
    logic              r_data_wrong;
    logic              r_len_err;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_locked;
    logic              r_hunt;

    logic [7:0]        w_rx;
    logic              w_len_bad;
    logic [3:0]        w_run_next;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc_byte(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
        return (v >= LP_LOCK) ? LP_LOCK : v + 4'd1;
    endfunction

    // Byte as it would complete on this edge: seven stored bits plus the live one.
    assign w_rx       = {r_sreg, bus.DataOut};
    assign w_len_bad  = (r_bit_cnt != 3'd0) || (r_byte_cnt != LP_PAYLOAD);
    assign w_run_next = sat_inc_run(r_good_run);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_HUNT;
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_expected   <= '0;
            r_good_run   <= '0;
            r_frame_bad  <= 1'b0;
            r_en_d       <= 1'b0;
            r_data_wrong <= 1'b0;
            r_len_err    <= 1'b0;
            r_err_cnt    <= '0;
            r_frame_cnt  <= '0;
            r_locked     <= 1'b0;
            r_hunt       <= 1'b1;
        end else begin
            r_data_wrong <= 1'b0;
            r_len_err    <= 1'b0;
            r_en_d       <= bus.DataOutEn;

            if (bus.DataOutEn) begin
                r_sreg    <= w_rx[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_cnt <= sat_inc_byte(r_byte_cnt);
                    // Seeding, a match and a resync all leave the reference at rx+1.
                    r_expected <= w_rx + 8'd1;
                    if (r_state == ST_HUNT) begin
                        r_state <= ST_CHECK;
                        r_hunt  <= 1'b0;
                    end else if (w_rx != r_expected) begin
                        r_data_wrong <= 1'b1;
                        r_frame_bad  <= 1'b1;
                        r_err_cnt    <= sat_inc_err(r_err_cnt);
                    end
                end
            end else if (r_en_d) begin
                // Frame end: falling edge of the enable window.
                r_frame_cnt <= r_frame_cnt + 1'b1;
                if (w_len_bad) begin
                    r_len_err <= 1'b1;
                    r_err_cnt <= sat_inc_err(r_err_cnt);
                end
                if (r_frame_bad || w_len_bad) begin
                    r_good_run <= '0;
                    r_locked   <= 1'b0;
                end else begin
                    r_good_run <= w_run_next;
                    r_locked   <= (w_run_next == LP_LOCK);
                end
                r_bit_cnt   <= '0;
                r_byte_cnt  <= '0;
                r_frame_bad <= 1'b0;
                r_sreg      <= '0;
            end
        end
    end

    assign bus.DataWrong  = r_data_wrong;
    assign bus.LenErr     = r_len_err;
    assign bus.ErrCount   = r_err_cnt;
    assign bus.FrameCount = r_frame_cnt;
    assign bus.Locked     = r_locked;
    assign bus.Hunt       = r_hunt;

endmodule

// File: doc/frame_payload_checker.md
Name: frame_payload_checker

Overview:
- Downstream consumer of the frame synchroniser. Takes its serial payload stream (DataOut qualified by DataOutEn) and deserialises it MSB-first into bytes.
- Checks each byte against a self-seeding incrementing (mod-256) reference and checks frame length.
- Reports per-byte and per-frame errors, a saturating error count, a frame count and a lock flag for the frame-link bench and status logic.

Parameters:
- PAYLOAD_BYTES, 31, payload bytes expected per frame (enable-high window); legal 1..255
- LOCK_FRAMES, 4, consecutive good frames required to set Locked; legal 1..15
- ERR_W, 16, width of ErrCount
- FCNT_W, 16, width of FrameCount

Ports:
- Clock  input  1  single system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- DataOut  input  1  serial payload bit from frame synchroniser
- DataOutEn  input  1  high while DataOut carries a valid payload bit; one frame = one contiguous high window
- DataWrong  output  1  one-cycle pulse: received byte != expected byte
- LenErr  output  1  one-cycle pulse: frame ended with wrong bit/byte count
- ErrCount  output  ERR_W  saturating count of DataWrong plus LenErr events
- FrameCount  output  FCNT_W  completed frames (good or bad), wraps
- Locked  output  1  LOCK_FRAMES consecutive good frames seen
- Hunt  output  1  checker has no reference byte yet (state HUNT)

Behaviour:
- Reset (async, any time, including mid-frame): DataWrong=0, LenErr=0, ErrCount=0, FrameCount=0, Locked=0, Hunt=1. Shift register, bit_cnt, byte_cnt, expected, good-run counter, frame-bad flag and en_d all cleared. State=HUNT.
- Deserialise: on each edge with DataOutEn=1, shift DataOut into sreg (MSB first) and increment bit_cnt (3 bits).
- When bit_cnt==7 the byte completes as rx={sreg[6:0],DataOut}. bit_cnt wraps to 0 and byte_cnt increments; byte_cnt saturates at 255.
- FSM, two states:
  - HUNT: on the first completed byte, expected<=rx+1 and go to CHECK. No compare and no error for that byte. That frame can still be judged good (its length check still applies).
  - CHECK: on each completed byte, compare rx with expected.
    - Match: expected<=expected+1.
    - Mismatch: DataWrong=1 for exactly the next cycle (registered output), expected<=rx+1 (resync), frame-bad flag set.
  - CHECK never returns to HUNT except via Reset.
- expected and rx arithmetic is 8-bit, wraps 0xFF->0x00 with no error.
- Expected sequence continues across frame boundaries; it is not restarted per frame.
- Frame end: en_d==1 and DataOutEn==0 (registered falling edge).
  - LenErr pulses one cycle if bit_cnt!=0 or byte_cnt!=PAYLOAD_BYTES; frame-bad is then also treated as set.
  - FrameCount increments and wraps.
  - If the frame is good: good-run counter increments, saturating at LOCK_FRAMES; Locked=1 when it reaches LOCK_FRAMES.
  - If the frame is bad: good-run counter=0 and Locked=0 in the same cycle as LenErr/frame accounting.
  - bit_cnt, byte_cnt and frame-bad are cleared; partial sreg contents are discarded.
- A byte completion and a frame end cannot coincide on the same edge, because completion needs DataOutEn=1 and frame end needs DataOutEn=0. The two error sources are therefore never simultaneous.
- ErrCount increments by 1 per DataWrong or LenErr pulse and holds at all-ones (no wrap).
- A DataOutEn low gap of any length is simply the inter-frame gap; no timeout.
- A DataOutEn window of a single cycle is a valid (short) frame and gives LenErr.
- All outputs are registered. DataWrong/LenErr latency: one cycle after the triggering edge.

Test Plan:
- Reset then 3 frames of 31 bytes carrying 0x10..0x6C continuous -> Hunt falls after 8 enabled bits, no DataWrong/LenErr, FrameCount=3, Locked=0, ErrCount=0.
- Continue good frames to 4 total -> Locked=1 in the cycle after the 4th frame-end edge.
- Corrupt byte 5 of frame 6 (send 0x00 instead of expected 0xAF), then continue from 0x01 -> single DataWrong pulse, ErrCount=1, Locked=0 at frame end, Locked=1 again after 4 further good frames.
- Frame with 30 bytes + 3 stray bits -> one LenErr at frame end, ErrCount increments by 1, no DataWrong; good-run resets.
- Sequence crosses 0xFE,0xFF,0x00,0x01 inside one frame -> no errors.
- Assert Reset mid-frame (after 13 bits), release, resume a new stream at 0x80 -> all outputs at reset values, Hunt=1 until first new byte, no LenErr for the aborted frame. Separately force ErrCount via ERR_W=2 with 5 errors -> holds at 3.
